calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the keypad calculator datapath.
- Consumes decoded keypad events and owns operand/operator entry.
- Issues a start/done handshake to the multi-cycle arithmetic unit and drives the 4-nibble seven-segment display bus.
- Sits between the keyboard decoder/key-code mapper and both the arithmetic unit and the display scanner.

Parameters:
- TIMEOUT, 255: max cycles waited in BUSY for alu_done before ERR; counter width = $clog2(TIMEOUT+1).
- BLANK, 4'hF: display nibble code for a blank digit.
- ERRC, 4'hE: display nibble code shown in every digit in ERR.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle pulse per accepted key press.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 clear, 15 enter, 14 ignored.
- alu_done  in  1  one-cycle pulse, result valid.
- alu_res  in  16  result, 4 BCD digits, [15:12] most significant.
- alu_start  out  1  one-cycle start pulse to the arithmetic unit.
- op_a  out  8  operand A, 2 BCD digits.
- op_b  out  8  operand B, 2 BCD digits.
- opr  out  4  operator code (10/11/12), BLANK when none.
- disp  out  16  nibbles to display scanner, [15:12] leftmost.
- state  out  3  0 ENTER_A, 1 ENTER_B, 2 BUSY, 3 SHOW, 4 ERR.
- err  out  1  high while in ERR.

Behaviour:
- Reset (rst_n low, asynchronous): state=ENTER_A, op_a=op_b=0, opr=BLANK, result reg=0, timer=0, alu_start=0, err=0.
- Keys are acted on only in the cycle key_valid=1; key_code 14 is always ignored.
- Digit entry shifts into the active operand: hi<=lo, lo<=digit. Only the 2 most recent digits are kept; older digits drop silently.
- Clear (13) in any state: op_a=op_b=0, opr=BLANK, timer=0, state=ENTER_A next cycle.
- ENTER_A:
  - digit -> shift into op_a.
  - operator -> opr<=code, go to ENTER_B.
  - enter -> ignored.
- ENTER_B:
  - digit -> shift into op_b.
  - operator -> replace opr, op_b unchanged.
  - enter -> go to BUSY, alu_start=1 for exactly the first BUSY cycle (registered, same edge as the state change), timer=0.
- BUSY:
  - op_a/op_b/opr held stable.
  - Non-clear keys are dropped.
  - timer increments each cycle.
  - alu_done -> latch alu_res, go to SHOW.
  - timer==TIMEOUT without done -> go to ERR.
  - done and timeout in the same cycle: done wins.
  - clear and alu_done in the same cycle: clear wins, result discarded.
  - A late alu_done arriving outside BUSY is ignored.
- SHOW: any key except 13/14 -> full clear, go to ENTER_A (optional feature modifies this).
- ERR: err=1; any key except 14 -> full clear, go to ENTER_A.
- disp, combinational from registers:
  - ENTER_A: {opr, BLANK, op_a}
  - ENTER_B: {opr, BLANK, op_b}
  - BUSY: {opr, BLANK, op_b}
  - SHOW: result reg
  - ERR: {ERRC x4}
- alu_start is never asserted outside the first BUSY cycle and never twice per computation.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: in SHOW, an operator key loads op_a<=result[7:0], opr<=code, op_b<=0, and goes to ENTER_B (chained calculation); digit/enter keys behave as without the macro.
- Undefined: every non-ignored key in SHOW performs a full clear to ENTER_A; the result is never fed back.

Test Plan:
- Reset mid-BUSY (rst_n low 1 cycle) -> immediately state=0, opr=4'hF, alu_start=0, disp=16'hFF00.
- Keys 1,2,3 in ENTER_A -> op_a=8'h23, disp=16'hFF23; then '+' -> state=1, opr=10, disp=16'hAF00.
- A=12, '*', B=34, enter -> alu_start single pulse; alu_done 5 cycles later with alu_res=16'h0408 -> state=3, disp=16'h0408.
- alu_done withheld, TIMEOUT=255 -> ERR exactly 255 cycles after entering BUSY, disp=16'hEEEE, err=1; any key -> ENTER_A.
- In BUSY press digit 7 -> op_b unchanged; press clear in the same cycle as alu_done -> state=0, result not latched.
- CALC_CHAIN_EN: result 16'h0046, press '-' -> op_a=8'h46, opr=11, state=1; without the macro the same key -> state=0, op_a=0.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad calculator sequencer (operand entry, ALU handshake, display bus).
// Define CALC_CHAIN_EN to let an operator key in SHOW chain the result into operand A.
module calc_seq_ctrl #(
    parameter int         TIMEOUT = 255,
    parameter logic [3:0] BLANK   = 4'hF,
    parameter logic [3:0] ERRC    = 4'hE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alu_done,
    input  logic [15:0] alu_res,
    output logic        alu_start,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [3:0]  opr,
    output logic [15:0] disp,
    output logic [2:0]  state,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        BUSY    = 3'd2,
        SHOW    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t         cur, nxt;
    logic [7:0]     a_n, b_n;
    logic [3:0]     opr_n;
    logic [15:0]    res, res_n;
    logic [TW-1:0]  tmr, tmr_n;
    logic           start_n;
    logic           is_dig, is_op, is_clr, is_ent, is_any;

    assign is_dig = key_valid && key_code <= 4'd9;
    assign is_op  = key_valid && key_code >= 4'd10 && key_code <= 4'd12;
    assign is_clr = key_valid && key_code == 4'd13;
    assign is_ent = key_valid && key_code == 4'd15;
    assign is_any = key_valid && key_code != 4'd14;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= ENTER_A;
            op_a      <= '0;
            op_b      <= '0;
            opr       <= BLANK;
            res       <= '0;
            tmr       <= '0;
            alu_start <= 1'b0;
        end else begin
            cur       <= nxt;
            op_a      <= a_n;
            op_b      <= b_n;
            opr       <= opr_n;
            res       <= res_n;
            tmr       <= tmr_n;
            alu_start <= start_n;
        end
    end

    always_comb begin
        nxt     = cur;
        a_n     = op_a;
        b_n     = op_b;
        opr_n   = opr;
        res_n   = res;
        tmr_n   = tmr;
        start_n = 1'b0;
        if (is_clr) begin
            nxt   = ENTER_A;
            a_n   = '0;
            b_n   = '0;
            opr_n = BLANK;
            tmr_n = '0;
        end else begin
            case (cur)
                ENTER_A: begin
                    if (is_dig) a_n = {op_a[3:0], key_code};
                    else if (is_op) begin
                        opr_n = key_code;
                        nxt   = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_dig) b_n = {op_b[3:0], key_code};
                    else if (is_op) opr_n = key_code;
                    else if (is_ent) begin
                        nxt     = BUSY;
                        start_n = 1'b1;
                        tmr_n   = '0;
                    end
                end
                BUSY: begin
                    // ERR is entered on the same edge the timer reaches TIMEOUT; done has priority
                    if (alu_done) begin
                        res_n = alu_res;
                        nxt   = SHOW;
                    end else begin
                        tmr_n = tmr + 1'b1;
                        if (tmr_n == TW'(TIMEOUT)) nxt = ERR;
                    end
                end
                SHOW, ERR: begin
                    if (is_any) begin
                        nxt   = ENTER_A;
                        a_n   = '0;
                        b_n   = '0;
                        opr_n = BLANK;
                        tmr_n = '0;
                    end
`ifdef CALC_CHAIN_EN
                    if (cur == SHOW && is_op) begin
                        nxt   = ENTER_B;
                        a_n   = res[7:0];
                        b_n   = '0;
                        opr_n = key_code;
                    end
`endif
                end
                default: nxt = ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp = (cur == ENTER_A) ? {opr, BLANK, op_a} :
               (cur == SHOW)    ? res :
               (cur == ERR)     ? {4{ERRC}} :
                                  {opr, BLANK, op_b};
    end

    assign state = cur;
    assign err   = (cur == ERR);
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed self-checking bench for calc_seq_ctrl (default or CALC_CHAIN_EN build).
module tb_calc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_done = 1'b0;
    logic [15:0] alu_res = 16'd0;
    logic        alu_start, err;
    logic [7:0]  op_a, op_b;
    logic [3:0]  opr;
    logic [15:0] disp;
    logic [2:0]  state;
    int          n_cmp = 0;
    int          n_bad = 0;

    calc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_done(alu_done), .alu_res(alu_res), .alu_start(alu_start),
        .op_a(op_a), .op_b(op_b), .opr(opr), .disp(disp), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic done_with(input logic [15:0] r);
        alu_done = 1'b1;
        alu_res  = r;
        tick();
        alu_done = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_opr", opr, 16'hF);
        chk("rst_disp", disp, 16'hFF00);
        chk("rst_start", alu_start, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        press(1); press(2); press(3);
        chk("a_shift", op_a, 16'h23);
        chk("a_disp", disp, 16'hFF23);
        press(15);
        chk("a_enter_ign", state, 0);
        press(14);
        chk("a_key14", op_a, 16'h23);
        press(10);
        chk("plus_state", state, 1);
        chk("plus_opr", opr, 16'hA);
        chk("plus_disp", disp, 16'hAF00);
        press(13);
        chk("clr_state", state, 0);
        chk("clr_opa", op_a, 0);

        press(1); press(2); press(12); press(3); press(4);
        chk("b_shift", op_b, 16'h34);
        chk("b_disp", disp, 16'hCF34);
        press(15);
        chk("busy_state", state, 2);
        chk("start_hi", alu_start, 1);
        chk("busy_disp", disp, 16'hCF34);
        tick();
        chk("start_lo1", alu_start, 0);
        tick(); tick();
        press(7);
        chk("busy_opb", op_b, 16'h34);
        chk("busy_hold", state, 2);
        chk("start_lo2", alu_start, 0);
        done_with(16'h0408);
        chk("show_state", state, 3);
        chk("show_disp", disp, 16'h0408);
        done_with(16'h1111);
        chk("late_done", disp, 16'h0408);
        press(14);
        chk("show_key14", state, 3);
        press(5);
        chk("show_dig_state", state, 0);
        chk("show_dig_opa", op_a, 0);

        press(2); press(10); press(11);
        chk("op_replace", opr, 16'hB);
        press(3); press(15);
        done_with(16'h0046);
        chk("chain_show", disp, 16'h0046);
        press(11);
`ifdef CALC_CHAIN_EN
        chk("chain_state", state, 1);
        chk("chain_opa", op_a, 16'h46);
        chk("chain_opr", opr, 16'hB);
        chk("chain_disp", disp, 16'hBF00);
`else
        chk("nochain_state", state, 0);
        chk("nochain_opa", op_a, 0);
        chk("nochain_opr", opr, 16'hF);
`endif
        press(13);

        press(1); press(10); press(2); press(15);
        repeat (254) tick();
        chk("pre_timeout", state, 2);
        tick();
        chk("timeout_state", state, 4);
        chk("timeout_disp", disp, 16'hEEEE);
        chk("timeout_err", err, 1);
        press(14);
        chk("err_key14", state, 4);
        press(5);
        chk("err_exit", state, 0);
        chk("err_lo", err, 0);

        press(1); press(10); press(2); press(15);
        tick();
        key_valid = 1'b1; key_code = 4'd13; alu_done = 1'b1; alu_res = 16'h9999;
        tick();
        key_valid = 1'b0; alu_done = 1'b0;
        chk("clr_done_state", state, 0);
        chk("clr_done_disp", disp, 16'hFF00);

        press(4); press(11); press(6); press(15);
        chk("pre_rst_start", alu_start, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_opr", opr, 16'hF);
        chk("arst_start", alu_start, 0);
        chk("arst_disp", disp, 16'hFF00);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
